// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - in-order ALU result buffer feeding register-file writeback
module alu_wb_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_we,
  output logic              wb_zero,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [REG_W-1:0]  rd_mem   [DEPTH];
  logic              we_mem   [DEPTH];

  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] nptr;
  logic [CNT_W-1:0] count;
  logic             alive;
  logic             push;
  logic             pop;

  // alive keeps in_ready low while rst is high and for the cycle it is released
  assign in_ready  = alive && (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign nptr      = wptr - PTR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      alive <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        rd_mem[i]   <= '0;
        we_mem[i]   <= 1'b0;
      end
    end else begin
      alive <= 1'b1;
      if (flush) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          data_mem[wptr] <= in_data;
          rd_mem[wptr]   <= in_rd;
          // register 0 is hardwired, so its writes are dropped at capture
          we_mem[wptr]   <= in_we && (in_rd != '0);
          wptr           <= wptr + PTR_W'(1);
        end
        if (pop) begin
          rptr <= rptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    wb_data = '0;
    wb_rd   = '0;
    wb_we   = 1'b0;
    if (out_valid) begin
      wb_data = data_mem[rptr];
      wb_rd   = rd_mem[rptr];
      wb_we   = we_mem[rptr];
    end
  end

  assign wb_zero = out_valid && (wb_data == '0);

  always_comb begin
    fwd_valid = out_valid && we_mem[nptr];
    fwd_rd    = '0;
    fwd_data  = '0;
    if (fwd_valid) begin
      fwd_rd   = rd_mem[nptr];
      fwd_data = data_mem[nptr];
    end
  end

  assign occupancy = count;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - directed self-checking bench for alu_wb_buffer
module tb_alu_wb_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        wb_zero;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  int checks = 0;
  int failures = 0;

  alu_wb_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .wb_zero(wb_zero),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] d, input logic [4:0] r, input logic we);
    in_valid = 1'b1;
    in_data  = d;
    in_rd    = r;
    in_we    = we;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    int          sent;
    int          recv;
    int          mcount;
    bit          mpush;
    bit          mpop;

    // power-on reset
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // reset mid-operation
    offer(32'hA5A5A5A5, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mid_occ", occupancy, 1);
    chk("mid_wb_data", wb_data, 32'hA5A5A5A5);
    chk("mid_fwd_valid", fwd_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_occ", occupancy, 0);
    chk("async_wb_data", wb_data, 0);
    chk("async_fwd_valid", fwd_valid, 0);
    #1 rst = 1'b0;
    tick();
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);

    // single pass
    out_ready = 1'b1;
    offer(32'h0000F0F0, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("sp_out_valid", out_valid, 1);
    chk("sp_wb_data", wb_data, 32'h0000F0F0);
    chk("sp_wb_rd", wb_rd, 7);
    chk("sp_wb_we", wb_we, 1);
    chk("sp_wb_zero", wb_zero, 0);
    chk("sp_occ1", occupancy, 1);
    tick();
    chk("sp_occ0", occupancy, 0);
    chk("sp_out_valid0", out_valid, 0);

    // fill and backpressure
    out_ready = 1'b0;
    offer(32'h11, 5'd1, 1'b1);
    tick();
    offer(32'h22, 5'd2, 1'b1);
    tick();
    chk("bp_occ_full", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    offer(32'h33, 5'd3, 1'b1);
    tick();
    chk("bp_occ_hold", occupancy, 2);
    chk("bp_head_11", wb_data, 32'h11);
    out_ready = 1'b1;
    tick();
    chk("bp_occ_after_pop", occupancy, 1);
    chk("bp_head_22", wb_data, 32'h22);
    chk("bp_in_ready_again", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_occ_swap", occupancy, 1);
    chk("bp_head_33", wb_data, 32'h33);
    tick();
    chk("bp_occ_drained", occupancy, 0);

    // forwarding and rd=0
    out_ready = 1'b0;
    offer(32'h0, 5'd0, 1'b1);
    tick();
    chk("fw_r0_fwd_valid", fwd_valid, 0);
    chk("fw_r0_fwd_rd", fwd_rd, 0);
    offer(32'hDEADBEEF, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("fw_fwd_valid", fwd_valid, 1);
    chk("fw_fwd_rd", fwd_rd, 9);
    chk("fw_fwd_data", fwd_data, 32'hDEADBEEF);
    chk("fw_r0_wb_we", wb_we, 0);
    chk("fw_r0_wb_zero", wb_zero, 1);
    chk("fw_r0_wb_rd", wb_rd, 0);
    out_ready = 1'b1;
    tick();
    chk("fw_head_data", wb_data, 32'hDEADBEEF);
    chk("fw_head_we", wb_we, 1);
    chk("fw_head_zero", wb_zero, 0);
    chk("fw_head_rd", wb_rd, 9);
    tick();
    chk("fw_occ_drained", occupancy, 0);

    // flush priority
    out_ready = 1'b0;
    offer(32'h55, 5'd4, 1'b1);
    tick();
    offer(32'h66, 5'd5, 1'b1);
    tick();
    chk("fl_occ_full", occupancy, 2);
    flush = 1'b1;
    out_ready = 1'b1;
    offer(32'h77, 5'd6, 1'b1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_fwd_valid", fwd_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_wb_data", wb_data, 0);
    offer(32'h88, 5'd8, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("fl_next_head", wb_data, 32'h88);
    chk("fl_next_fwd", fwd_data, 32'h88);
    chk("fl_next_occ", occupancy, 1);
    out_ready = 1'b1;
    tick();
    chk("fl_next_drained", occupancy, 0);

    // wrap-around streaming with toggling out_ready
    sent = 0;
    recv = 0;
    mcount = 0;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent == 10 && mcount == 0) break;
      if (sent < 10) offer(32'h100 + 32'(sent), 5'(sent + 1), 1'b1);
      else in_valid = 1'b0;
      mpush = (sent < 10) && (mcount != 2);
      mpop  = (mcount != 0) && out_ready;
      chk("wr_in_ready", in_ready, (mcount != 2) ? 1 : 0);
      chk("wr_occ", occupancy, 32'(mcount));
      if (mcount != 0) chk("wr_head", wb_data, exp_q[0]);
      tick();
      if (mpop) begin
        void'(exp_q.pop_front());
        recv++;
        mcount--;
      end
      if (mpush) begin
        exp_q.push_back(32'h100 + 32'(sent));
        sent++;
        mcount++;
      end
      out_ready = ~out_ready;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wr_recv_count", 32'(recv), 10);
    chk("wr_final_occ", occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
